// File: rtl/vcve2_vrf_arbiter.sv
// Two-port arbiter in front of the single-port vector register file RAM.
// EX and LS share one access per cycle: round-robin on conflict, lockable bursts.
module vcve2_vrf_arbiter #(
    parameter int unsigned VLEN      = 128,
    parameter int unsigned AddrWidth = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 ex_req_i,
    input  logic                 ex_we_i,
    input  logic [AddrWidth-1:0] ex_addr_i,
    input  logic [VLEN-1:0]      ex_wdata_i,
    input  logic                 ex_lock_i,
    output logic                 ex_gnt_o,
    output logic                 ex_rvalid_o,
    output logic [VLEN-1:0]      ex_rdata_o,

    input  logic                 ls_req_i,
    input  logic                 ls_we_i,
    input  logic [AddrWidth-1:0] ls_addr_i,
    input  logic [VLEN-1:0]      ls_wdata_i,
    input  logic                 ls_lock_i,
    output logic                 ls_gnt_o,
    output logic                 ls_rvalid_o,
    output logic [VLEN-1:0]      ls_rdata_o,

    output logic                 ram_req_o,
    output logic                 ram_we_o,
    output logic [AddrWidth-1:0] ram_addr_o,
    output logic [VLEN-1:0]      ram_wdata_o,
    input  logic [VLEN-1:0]      ram_rdata_i
);

    localparam logic [1:0] ARB_FREE = 2'd0;
    localparam logic [1:0] OWN_EX   = 2'd1;
    localparam logic [1:0] OWN_LS   = 2'd2;

    logic [1:0] state_q, state_d;
    logic       last_ls_q, last_ls_d;   // 1: LS was granted most recently
    logic       pend_q, pend_d;
    logic       pend_ls_q, pend_ls_d;
    logic       ex_gnt, ls_gnt;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        ex_gnt = 1'b0;
        ls_gnt = 1'b0;
        case (state_q)
            OWN_EX:  ex_gnt = ex_req_i;
            OWN_LS:  ls_gnt = ls_req_i;
            default: begin
                if (ex_req_i && ls_req_i) begin
                    ex_gnt = last_ls_q;
                    ls_gnt = !last_ls_q;
                end else begin
                    ex_gnt = ex_req_i;
                    ls_gnt = ls_req_i;
                end
            end
        endcase
        // Grants are combinational, so they must be forced low while reset is held.
        if (!rst_ni) begin
            ex_gnt = 1'b0;
            ls_gnt = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OWN_EX:  if (!ex_lock_i) state_d = ARB_FREE;
            OWN_LS:  if (!ls_lock_i) state_d = ARB_FREE;
            default: begin
                state_d = ARB_FREE;
                if (ex_gnt && ex_lock_i)      state_d = OWN_EX;
                else if (ls_gnt && ls_lock_i) state_d = OWN_LS;
            end
        endcase
    end

    assign last_ls_d = ls_gnt ? 1'b1 : (ex_gnt ? 1'b0 : last_ls_q);
    assign pend_d    = (ex_gnt && !ex_we_i) || (ls_gnt && !ls_we_i);
    assign pend_ls_d = ls_gnt;

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_FREE;
            last_ls_q <= 1'b1;
            pend_q    <= 1'b0;
            pend_ls_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_ls_q <= last_ls_d;
            pend_q    <= pend_d;
            pend_ls_q <= pend_ls_d;
        end
    end

    assign ex_gnt_o    = ex_gnt;
    assign ls_gnt_o    = ls_gnt;

    assign ram_req_o   = ex_gnt | ls_gnt;
    assign ram_we_o    = (ex_gnt & ex_we_i) | (ls_gnt & ls_we_i);
    assign ram_addr_o  = ({AddrWidth{ex_gnt}} & ex_addr_i) | ({AddrWidth{ls_gnt}} & ls_addr_i);
    assign ram_wdata_o = ({VLEN{ex_gnt}} & ex_wdata_i) | ({VLEN{ls_gnt}} & ls_wdata_i);

    // Read data is steered by the owner tag captured with the grant.
    assign ex_rvalid_o = pend_q & ~pend_ls_q;
    assign ls_rvalid_o = pend_q & pend_ls_q;
    assign ex_rdata_o  = {VLEN{ex_rvalid_o}} & ram_rdata_i;
    assign ls_rdata_o  = {VLEN{ls_rvalid_o}} & ram_rdata_i;

endmodule

// File: tb/tb_vcve2_vrf_arbiter.sv
// Directed bench for vcve2_vrf_arbiter with a behavioural RAM and a read scoreboard.
module tb_vcve2_vrf_arbiter;

    localparam int unsigned VLEN = 128;
    localparam int unsigned AW   = 5;
    localparam logic [1:0]  G_NONE = 2'd0;
    localparam logic [1:0]  G_EX   = 2'd1;
    localparam logic [1:0]  G_LS   = 2'd2;

    typedef struct packed {
        logic            owner_ls;
        logic [VLEN-1:0] data;
    } rd_exp_t;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            ex_req_i, ex_we_i, ex_lock_i, ls_req_i, ls_we_i, ls_lock_i;
    logic [AW-1:0]   ex_addr_i, ls_addr_i;
    logic [VLEN-1:0] ex_wdata_i, ls_wdata_i;
    logic            ex_gnt_o, ls_gnt_o, ex_rvalid_o, ls_rvalid_o;
    logic [VLEN-1:0] ex_rdata_o, ls_rdata_o;
    logic            ram_req_o, ram_we_o;
    logic [AW-1:0]   ram_addr_o;
    logic [VLEN-1:0] ram_wdata_o, ram_rdata_i;

    logic [VLEN-1:0] mem     [32];
    logic [VLEN-1:0] ref_mem [32];
    rd_exp_t         sb[$];
    int              tests  = 0;
    int              failed = 0;

    always #5 clk_i = ~clk_i;

    vcve2_vrf_arbiter #(.VLEN(VLEN), .AddrWidth(AW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_req_i(ex_req_i), .ex_we_i(ex_we_i), .ex_addr_i(ex_addr_i),
        .ex_wdata_i(ex_wdata_i), .ex_lock_i(ex_lock_i), .ex_gnt_o(ex_gnt_o),
        .ex_rvalid_o(ex_rvalid_o), .ex_rdata_o(ex_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_lock_i(ls_lock_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    function automatic logic [VLEN-1:0] init_word(int i);
        logic [31:0] w;
        w = 32'h5A00_0000 + i;
        return {4{w}};
    endfunction

    function automatic logic [VLEN-1:0] wr_word(int i);
        logic [31:0] w;
        w = 32'hD0D0_0000 + i;
        return {4{w}};
    endfunction

    // Single-port RAM: one-cycle registered read.
    always @(posedge clk_i) begin
        if (ram_req_o) begin
            if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
            else          ram_rdata_i     <= mem[ram_addr_o];
        end
    end

    task automatic check(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic req, input logic we, input int addr,
                          input logic [VLEN-1:0] wdata, input logic lock);
        ex_req_i = req; ex_we_i = we; ex_addr_i = AW'(addr); ex_wdata_i = wdata; ex_lock_i = lock;
    endtask

    task automatic set_ls(input logic req, input logic we, input int addr,
                          input logic [VLEN-1:0] wdata, input logic lock);
        ls_req_i = req; ls_we_i = we; ls_addr_i = AW'(addr); ls_wdata_i = wdata; ls_lock_i = lock;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".ex_gnt"},    ex_gnt_o,    '0);
        check({tag, ".ls_gnt"},    ls_gnt_o,    '0);
        check({tag, ".ex_rvalid"}, ex_rvalid_o, '0);
        check({tag, ".ls_rvalid"}, ls_rvalid_o, '0);
        check({tag, ".ram_req"},   ram_req_o,   '0);
        check({tag, ".ram_we"},    ram_we_o,    '0);
        check({tag, ".ram_addr"},  ram_addr_o,  '0);
        check({tag, ".ram_wdata"}, ram_wdata_o, '0);
        check({tag, ".ex_rdata"},  ex_rdata_o,  '0);
        check({tag, ".ls_rdata"},  ls_rdata_o,  '0);
    endtask

    // One clock of traffic: check grant and RAM side, then the read return after the edge.
    task automatic cycle(input string tag, input logic [1:0] exp_g);
        logic            e_we;
        logic [AW-1:0]   e_addr;
        logic [VLEN-1:0] e_wdata;
        rd_exp_t         ent;
        #1;
        e_we = 1'b0; e_addr = '0; e_wdata = '0;
        if (exp_g == G_EX) begin
            e_we = ex_we_i; e_addr = ex_addr_i; e_wdata = ex_wdata_i;
        end else if (exp_g == G_LS) begin
            e_we = ls_we_i; e_addr = ls_addr_i; e_wdata = ls_wdata_i;
        end
        check({tag, ".ex_gnt"},    ex_gnt_o,    exp_g == G_EX);
        check({tag, ".ls_gnt"},    ls_gnt_o,    exp_g == G_LS);
        check({tag, ".ram_req"},   ram_req_o,   exp_g != G_NONE);
        check({tag, ".ram_we"},    ram_we_o,    e_we);
        check({tag, ".ram_addr"},  ram_addr_o,  e_addr);
        check({tag, ".ram_wdata"}, ram_wdata_o, e_wdata);
        if (exp_g != G_NONE) begin
            if (e_we) ref_mem[e_addr] = e_wdata;
            else      sb.push_back('{owner_ls: (exp_g == G_LS), data: ref_mem[e_addr]});
        end
        @(posedge clk_i);
        #1;
        if (sb.size() > 0) begin
            ent = sb.pop_front();
            check({tag, ".ex_rvalid"}, ex_rvalid_o, !ent.owner_ls);
            check({tag, ".ls_rvalid"}, ls_rvalid_o, ent.owner_ls);
            check({tag, ".ex_rdata"},  ex_rdata_o,  ent.owner_ls ? '0 : ent.data);
            check({tag, ".ls_rdata"},  ls_rdata_o,  ent.owner_ls ? ent.data : '0);
        end else begin
            check({tag, ".ex_rvalid"}, ex_rvalid_o, '0);
            check({tag, ".ls_rvalid"}, ls_rvalid_o, '0);
            check({tag, ".ex_rdata"},  ex_rdata_o,  '0);
            check({tag, ".ls_rdata"},  ls_rdata_o,  '0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        ram_rdata_i = '0;

        // Reset held with both requesters active: everything stays quiet.
        rst_ni = 1'b0;
        set_ex(1'b1, 1'b1, 3, wr_word(3), 1'b1);
        set_ls(1'b1, 1'b0, 7, '0, 1'b1);
        #1;
        check_idle_outputs("rst");
        repeat (2) @(posedge clk_i);
        #1;
        check_idle_outputs("rst_hold");
        @(negedge clk_i);
        set_ex(1'b0, 1'b0, 0, '0, 1'b0);
        set_ls(1'b0, 1'b0, 0, '0, 1'b0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Round-robin reads on conflict: EX, LS, EX.
        set_ex(1'b1, 1'b0, 3, '0, 1'b0);
        set_ls(1'b1, 1'b0, 7, '0, 1'b0);
        cycle("rr0", G_EX);
        cycle("rr1", G_LS);
        cycle("rr2", G_EX);

        // Write then same-address read on the next cycle.
        set_ls(1'b0, 1'b0, 0, '0, 1'b0);
        set_ex(1'b1, 1'b1, 5, {16{8'hA5}}, 1'b0);
        cycle("wr5", G_EX);
        set_ex(1'b1, 1'b0, 5, '0, 1'b0);
        cycle("rd5", G_EX);

        // Single LS read so EX wins the next conflict.
        set_ex(1'b0, 1'b0, 0, '0, 1'b0);
        set_ls(1'b1, 1'b0, 7, '0, 1'b0);
        cycle("ls7", G_LS);

        // EX locked write burst 8..11 while LS waits on a read of 9.
        set_ls(1'b1, 1'b0, 9, '0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            set_ex(1'b1, 1'b1, 8 + b, wr_word(8 + b), b != 3);
            cycle($sformatf("burst%0d", b), G_EX);
        end
        set_ex(1'b0, 1'b0, 0, '0, 1'b0);
        cycle("burst_ls", G_LS);

        // EX takes ownership, then idles holding the lock.
        set_ex(1'b1, 1'b1, 12, wr_word(12), 1'b1);
        set_ls(1'b1, 1'b0, 12, '0, 1'b0);
        cycle("own_ex", G_EX);
        set_ex(1'b0, 1'b0, 0, '0, 1'b1);
        cycle("idle0", G_NONE);
        cycle("idle1", G_NONE);
        set_ex(1'b0, 1'b0, 0, '0, 1'b0);
        cycle("unlock", G_NONE);
        cycle("ls12", G_LS);

        // LS ownership blocks EX for one beat after it locks.
        set_ls(1'b0, 1'b0, 0, '0, 1'b0);
        set_ex(1'b1, 1'b0, 3, '0, 1'b0);
        cycle("ex3", G_EX);
        set_ls(1'b1, 1'b1, 20, wr_word(20), 1'b1);
        cycle("own_ls", G_LS);
        set_ls(1'b1, 1'b0, 20, '0, 1'b0);
        cycle("ls_beat", G_LS);
        set_ls(1'b1, 1'b0, 7, '0, 1'b0);
        cycle("after_ls", G_EX);

        // LS read granted, reset asserted in the next cycle: the return is discarded.
        set_ex(1'b0, 1'b0, 0, '0, 1'b0);
        set_ls(1'b1, 1'b0, 7, '0, 1'b0);
        #1;
        check("rstmid.ls_gnt", ls_gnt_o, 1'b1);
        @(posedge clk_i);
        rst_ni = 1'b0;
        sb.delete();
        set_ex(1'b1, 1'b0, 3, '0, 1'b1);
        set_ls(1'b1, 1'b0, 7, '0, 1'b1);
        #1;
        check_idle_outputs("rstmid");
        @(posedge clk_i);
        #1;
        check_idle_outputs("rstmid_hold");
        @(negedge clk_i);
        set_ex(1'b1, 1'b0, 3, '0, 1'b0);
        set_ls(1'b1, 1'b0, 7, '0, 1'b0);
        rst_ni = 1'b1;
        cycle("post_rst", G_EX);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vcve2_vrf_arbiter.md
VCVE2_VRF_ARBITER -- requirements
Module: vcve2_vrf_arbiter

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector register width in bits (RAM word width).
REQ-002 SHALL have parameter AddrWidth, default 5, VRF RAM address width (32 registers).
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports ex_req_i/ls_req_i  input  1  access request from execution sequencer (EX) / load-store unit (LS).
REQ-006 SHALL have ports ex_we_i/ls_we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports ex_addr_i/ls_addr_i  input  AddrWidth  register address.
REQ-008 SHALL have ports ex_wdata_i/ls_wdata_i  input  VLEN  write data.
REQ-009 SHALL have ports ex_lock_i/ls_lock_i  input  1  hold ownership after this grant (register-group burst).
REQ-010 SHALL have ports ex_gnt_o/ls_gnt_o  output  1  request accepted this cycle.
REQ-011 SHALL have ports ex_rvalid_o/ls_rvalid_o  output  1  read data valid.
REQ-012 SHALL have ports ex_rdata_o/ls_rdata_o  output  VLEN  read data.
REQ-013 SHALL have ports ram_req_o, ram_we_o  output  1  single-port RAM request / write enable.
REQ-014 SHALL have ports ram_addr_o  output  AddrWidth, ram_wdata_o  output  VLEN  RAM address / write data.
REQ-015 SHALL have port ram_rdata_i  input  VLEN  RAM read data, valid one cycle after a read request.

Function
REQ-016 SHALL implement states ARB_FREE, OWN_EX, OWN_LS.
REQ-017 In ARB_FREE, single requester SHALL be granted combinationally in the same cycle as its req.
REQ-018 In ARB_FREE with both requesting, SHALL grant the requester not granted most recently (round-robin); last-granted pointer resets to LS so EX wins first conflict.
REQ-019 At most one gnt SHALL be high per cycle; gnt SHALL never be high without the matching req.
REQ-020 ram_req_o SHALL equal OR of grants; ram_we_o/addr/wdata SHALL be muxed from the granted requester; all SHALL be 0 when no grant.
REQ-021 Granted with lock_i=1 SHALL move ARB_FREE -> OWN_<granted> at the next edge.
REQ-022 In OWN_X only X SHALL be granted (whenever X requests); the other requester SHALL wait with gnt=0.
REQ-023 In OWN_X, a granted beat with lock_i=0, or a cycle with X req=0 and lock_i=0, SHALL return to ARB_FREE at the next edge; lock_i=1 with req=0 SHALL keep ownership (idle beat).
REQ-024 Last-granted pointer SHALL update on every grant, including locked beats.
REQ-025 Granted read SHALL set a 1-bit pending flag plus owner tag; next cycle the tagged requester's rvalid_o SHALL pulse high for exactly one cycle; the other rvalid_o stays 0.
REQ-026 rdata_o of a requester SHALL equal ram_rdata_i when its rvalid_o is 1, else 0.
REQ-027 Granted write SHALL complete in the grant cycle; no rvalid SHALL be produced.
REQ-028 Back-to-back reads (any requester mix) SHALL be accepted every cycle; throughput 1 access/cycle, read latency 1 cycle.
REQ-029 Same-address read immediately after write SHALL return the new data (RAM write-first ordering relied upon, no bypass in arbiter).

Reset
REQ-030 While rst_ni=0: state ARB_FREE, pointer LS, pending flag 0, all gnt/rvalid/ram_* outputs 0 irrespective of req inputs.
REQ-031 Reset asserted mid-burst SHALL drop ownership and discard any pending read (no rvalid after release).
REQ-032 First edge after release SHALL behave as ARB_FREE with EX priority on conflict.

Verification
REQ-033 Both req, ex_addr=3, ls_addr=7, reads, no lock, 3 cycles -> gnt order EX,LS,EX; ram_addr 3,7,3; rvalid one cycle later to EX,LS,EX.
REQ-034 EX lock burst writes addr 8..11 (lock=1,1,1,0) with LS req held -> ls_gnt=0 for 4 cycles, LS granted cycle 5, state back to ARB_FREE.
REQ-035 EX write addr 5 data 0xA5..A5 then EX read addr 5 next cycle -> ex_rvalid next-next cycle, ex_rdata=0xA5..A5, ls_rvalid=0.
REQ-036 EX owns with lock=1, req=0 for 2 cycles, LS requesting -> ls_gnt stays 0; EX drops lock -> LS granted next cycle.
REQ-037 LS read granted, rst_ni pulsed low in following cycle -> ls_rvalid_o=0 throughout, outputs 0, post-reset conflict grants EX.
